// File: rtl/csa_addr_seq.sv
// Two-port round-robin sequencer that runs NBYTES-wide add/subtract operations
// through a shared external 8-bit byte adder, one byte per cycle, LSB first.
module csa_addr_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [8*NBYTES-1:0]   req0_a,
    input  logic [8*NBYTES-1:0]   req0_b,
    input  logic                  req0_sub,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [8*NBYTES-1:0]   req1_a,
    input  logic [8*NBYTES-1:0]   req1_b,
    input  logic                  req1_sub,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_cin,
    input  logic [7:0]            add_sum,
    input  logic                  add_cout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [8*NBYTES-1:0]   rsp_sum,
    output logic                  rsp_cout,
    output logic                  rsp_ovf
);
    localparam int W  = 8 * NBYTES;
    localparam int KW = $clog2(NBYTES);
    localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    logic [KW-1:0]   r_k;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic            r_sub;
    logic            r_id;
    logic            r_carry;
    logic            r_ovf;
    logic            r_last;

    logic            w_sel1;
    logic            w_accept;
    logic [W-1:0]    w_op_a;
    logic [W-1:0]    w_op_b;
    logic            w_op_sub;

    function automatic logic f_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // r_last resets to 1 so that req0 wins the first contested grant.
    always_comb begin
        w_sel1     = req1_valid && (!req0_valid || !r_last);
        req0_ready = (r_state == S_IDLE) && req0_valid && !w_sel1;
        req1_ready = (r_state == S_IDLE) && w_sel1;
        w_accept   = req0_ready || req1_ready;
        w_op_a     = w_sel1 ? req1_a   : req0_a;
        w_op_b     = w_sel1 ? req1_b   : req0_b;
        w_op_sub   = w_sel1 ? req1_sub : req0_sub;
    end

    // Operands shift down one byte per RUN cycle, so the low byte is always byte k.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (r_state == S_RUN) begin
            add_a   = r_a[7:0];
            add_b   = r_b[7:0] ^ {8{r_sub}};
            add_cin = (r_k == '0) ? r_sub : r_carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_sub   <= 1'b0;
            r_id    <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_op_a;
                        r_b     <= w_op_b;
                        r_sub   <= w_op_sub;
                        r_id    <= w_sel1;
                        r_k     <= '0;
                        r_carry <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Result bytes enter at the top; after NBYTES shifts byte 0 sits at the bottom.
                    r_sum   <= {add_sum, r_sum[W-1:8]};
                    r_carry <= add_cout;
                    r_a     <= r_a >> 8;
                    r_b     <= r_b >> 8;
                    r_k     <= r_k + 1'b1;
                    if (r_k == K_LAST) begin
                        r_ovf   <= f_ovf(add_a[7], add_b[7], add_sum[7]);
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_last  <= r_id;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid = (r_state == S_DONE);
    assign rsp_id    = r_id;
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_carry;
    assign rsp_ovf   = r_ovf;

endmodule

// File: doc/csa_addr_seq.md
# csa_addr_seq

Multi-byte add/subtract sequencer and two-port arbiter for the team's shared 8-bit carry-skip byte adder. The block accepts NBYTES-wide operations from two requesters and arbitrates between them round-robin. It drives the external combinational byte adder one byte per cycle, least significant byte first, chaining the carry through a register. It then returns the full-width result with carry-out and signed overflow on a valid/ready response port.

## Interface
- NBYTES, default 4: operand width in bytes, at least 2; W = 8*NBYTES.
- clk  in  1  clock. Reset is rst_n, asynchronous, active-low; clock is clk.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  W  operands.
- req0_sub / req1_sub  in  1  0 = a+b, 1 = a−b.
- add_a, add_b  out  8  byte operands to the shared byte adder.
- add_cin  out  1  byte adder carry-in.
- add_sum  in  8  byte adder sum. It is combinational from add_a, add_b and add_cin.
- add_cout  in  1  byte adder carry-out.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  1  requester that issued the result.
- rsp_sum  out  W  result.
- rsp_cout  out  1  final carry-out. For subtract, 1 means no borrow.
- rsp_ovf  out  1  two's-complement overflow.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - Grant goes to the single valid requester.
  - If both requesters are valid, grant goes to the requester not served last. After reset, req0 has priority.
  - reqN_ready is asserted combinationally, only for the granted requester, and only in IDLE.
  - On the handshake edge the block latches a, b, sub and id, clears k = 0, and moves to RUN.
- RUN, byte k:
  - add_a = a[8k+7:8k].
  - add_b = b[8k+7:8k] XOR {8{sub}}.
  - add_cin = sub when k = 0; otherwise add_cin = carry_reg.
  - On each edge: sum[8k+7:8k] <= add_sum, carry_reg <= add_cout, k <= k+1.
  - After byte NBYTES−1 the block moves to DONE.
- Outputs outside RUN: add_a, add_b and add_cin are 0.
- DONE:
  - rsp_valid = 1.
  - rsp_sum, rsp_cout and rsp_id stay stable until the rsp_ready handshake. The block then returns to IDLE and records last_served = id.
- Overflow: rsp_ovf = (a[W−1] == b'[W−1]) && (sum[W−1] != a[W−1]), where b' is b after the conditional invert.
- Only one operation is in flight at a time. Requests are not accepted in RUN or DONE; both ready outputs are 0 there.
- Requester rules:
  - A requester must hold its operands while valid && !ready.
  - The block samples operands only on the handshake edge.
- Reset, including mid-RUN or mid-DONE:
  - The operation is aborted and the FSM returns to IDLE.
  - rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, add_a, add_b, add_cin and carry_reg all reset to 0.
  - Priority returns to req0.
  - No partial response is ever emitted.

## Timing
- The request handshake happens at edge E0.
- Byte k is registered at edge E(k+1).
- rsp_valid rises after edge E(NBYTES), so latency is NBYTES cycles from acceptance to result.
- If rsp_ready is high when rsp_valid rises, the response handshake occurs at edge E(NBYTES+1). The earliest next acceptance is edge E(NBYTES+2), giving a peak throughput of 1 operation per NBYTES+2 cycles.
- rsp_ready has no combinational path to any req*_ready. A response retired at edge E returns the FSM to IDLE, and a new grant becomes possible in the following cycle.
- The byte adder path (add_* out to add_sum/add_cout in) must close in one clk period. The block adds no retiming.

## Test plan
All scenarios use NBYTES = 4.

1. req0 issues 0x000000FF + 0x00000001 with sub = 0.
   - Required: rsp_sum = 0x00000100, rsp_cout = 0, rsp_ovf = 0, rsp_id = 0.
   - rsp_valid must rise exactly 4 cycles after the accept edge.
   - add_cin must be 0, 1, 0, 0 across the four RUN cycles.
2. Full carry ripple across all bytes:
   - 0xFFFFFFFF + 0x00000001 → rsp_sum 0x00000000, cout 1, ovf 0.
   - 0x7FFFFFFF + 0x00000001 → rsp_sum 0x80000000, cout 0, ovf 1.
3. Subtract:
   - 0x00000005 − 0x00000007 → rsp_sum 0xFFFFFFFE, cout 0, ovf 0.
   - 0x80000000 − 0x00000001 → rsp_sum 0x7FFFFFFF, cout 1, ovf 1.
4. Arbitration: after reset, hold req0_valid and req1_valid high continuously with rsp_ready = 1.
   - Required: grants alternate 0, 1, 0, 1 (rsp_id sequence).
   - Required: consecutive accepts are spaced exactly 6 cycles apart.
5. Backpressure: hold rsp_ready = 0 for 3 cycles after rsp_valid rises, with req1 pending.
   - Required: rsp_* outputs stay unchanged and both ready outputs stay 0.
   - Required: req1 is accepted only after the rsp handshake.
6. Reset mid-operation: assert rst_n = 0 during RUN at k = 2.
   - Required: all outputs read 0 immediately (asynchronous reset).
   - Required: after release, no response is emitted, and with both requesters valid, req0 is granted first.
